// File: rtl/fft_input_buffer.sv
// Ping-pong input buffer for a radix-2 FFT: real ADC samples are written bit-reversed
// into the fill bank while the engine reads the other bank in natural order.
module fft_input_buffer #(
   parameter int LOG2N = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic [LOG2N-1:0] rd_addr,
   output logic [15:0]      rd_data,
   output logic             frame_ready,
   input  logic             frame_done,
   output logic             overflow,
   output logic [7:0]       frame_cnt
);
   localparam int N = 1 << LOG2N;

   typedef enum logic {W_FILL, W_WAIT} wst_t;
   typedef enum logic {R_IDLE, R_BUSY} rst_t;

   wst_t             wst, wst_nxt;
   rst_t             rd_st, rd_nxt;
   logic [LOG2N-1:0] wr_cnt, wr_addr;
   logic             wr_bank, wr_bank_nxt, rd_bank;
   logic             accept, last, swap;
   logic [15:0]      wr_word;
   logic [15:0]      mem [0:1][0:N-1];

   assign sample_ready = (wst == W_FILL);
   assign frame_ready  = (rd_st == R_BUSY);
   assign accept       = sample_valid && sample_ready;
   assign last         = accept && (wr_cnt == LOG2N'(N-1));
   assign wr_word      = {sample_in, 8'h00};

   for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
      assign wr_addr[i] = wr_cnt[LOG2N-1-i];
   end

   always_comb begin
      wst_nxt = wst;
      rd_nxt  = rd_st;
      swap    = 1'b0;
      case (wst)
         W_FILL: if (last) begin
            if (rd_st == R_IDLE || frame_done) swap = 1'b1;
            else                               wst_nxt = W_WAIT;
         end
         W_WAIT: if (frame_done) begin
            swap    = 1'b1;
            wst_nxt = W_FILL;
         end
         default: wst_nxt = W_FILL;
      endcase
      if (swap)                              rd_nxt = R_BUSY;
      else if (rd_st == R_BUSY && frame_done) rd_nxt = R_IDLE;
   end

   // Reads resolve against the post-swap bank so a swap edge already serves the new frame.
   assign wr_bank_nxt = wr_bank ^ swap;
   assign rd_bank     = ~wr_bank_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wst       <= W_FILL;
         rd_st     <= R_IDLE;
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         frame_cnt <= 8'd0;
         overflow  <= 1'b0;
         rd_data   <= 16'h0000;
      end else begin
         wst     <= wst_nxt;
         rd_st   <= rd_nxt;
         wr_bank <= wr_bank_nxt;
         if (accept)                        wr_cnt    <= wr_cnt + LOG2N'(1);
         if (swap)                          frame_cnt <= frame_cnt + 8'd1;
         if (sample_valid && !sample_ready) overflow  <= 1'b1;
         // The final sample of a frame lands in the bank that becomes readable at this edge.
         if (accept && wr_bank == rd_bank && wr_addr == rd_addr)
            rd_data <= wr_word;
         else
            rd_data <= mem[rd_bank][rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_bank][wr_addr] <= wr_word;
   end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter LOG2N, default 6, meaning log2 of FFT length (N = 2^LOG2N = 64 points).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sample_in  input  8  signed two's-complement real ADC sample.
REQ-005 SHALL have port sample_valid  input  1  sample_in valid this cycle.
REQ-006 SHALL have port sample_ready  output  1  buffer accepts a sample this cycle.
REQ-007 SHALL have port rd_addr  input  LOG2N  natural-order read address from the FFT engine.
REQ-008 SHALL have port rd_data  output  16  complex word {real[15:8], imag[7:0]}, the butterfly operand format.
REQ-009 SHALL have port frame_ready  output  1  read bank holds a complete frame owned by the engine.
REQ-010 SHALL have port frame_done  input  1  single-cycle pulse: engine releases the read bank.
REQ-011 SHALL have port overflow  output  1  sticky: a sample was offered while sample_ready was low.
REQ-012 SHALL have port frame_cnt  output  8  count of frames handed to the engine, wraps 255->0.

Function
REQ-013 SHALL contain two N x 16 banks (ping-pong); wr_bank selects the fill bank, the read bank is always ~wr_bank.
REQ-014 SHALL accept a sample when sample_valid && sample_ready, writing {sample_in, 8'h00} to fill-bank address bitrev(wr_cnt), with bitrev reversing all LOG2N bits.
REQ-015 SHALL increment wr_cnt (LOG2N bits) per accepted sample, wrapping N-1 -> 0.
REQ-016 SHALL implement write FSM states FILL and WAIT; sample_ready = 1 only in FILL.
REQ-017 SHALL implement read FSM states IDLE and BUSY; frame_ready = 1 only in BUSY.
REQ-018 On the accept with wr_cnt = N-1: if read FSM is IDLE, or BUSY with frame_done asserted the same cycle, SHALL swap (toggle wr_bank, read FSM -> BUSY, write FSM stays FILL, frame_cnt += 1) at that edge; otherwise write FSM -> WAIT.
REQ-019 In WAIT, on frame_done SHALL swap at that edge, read FSM stays BUSY, write FSM -> FILL.
REQ-020 On frame_done in BUSY with no swap that edge SHALL set read FSM -> IDLE; frame_done in IDLE SHALL be ignored.
REQ-021 frame_ready SHALL remain 1 continuously across a swap coinciding with frame_done (no low cycle).
REQ-022 rd_data SHALL be registered: read-bank word at rd_addr sampled at edge k appears after edge k, one-cycle latency, independent of frame_ready.
REQ-023 A read address captured in the same cycle as a swap SHALL return data from the bank selected after the swap.
REQ-024 SHALL set overflow when sample_valid && !sample_ready; the sample SHALL be dropped and wr_cnt unchanged.
REQ-025 Writes to the fill bank SHALL never alter the read bank.

Reset
REQ-026 On rst_n low SHALL immediately force: write FSM FILL, read FSM IDLE, wr_cnt 0, wr_bank 0, frame_cnt 0, overflow 0, rd_data 16'h0000, frame_ready 0, sample_ready 1.
REQ-027 Bank contents SHALL NOT be reset; a frame is only presented after N fresh accepts following reset.
REQ-028 Reset asserted mid-fill or mid-read SHALL discard the partial frame; the first N accepts after release form frame 1.

Verification
REQ-029 Reset; accept samples k = 0..63 back-to-back -> frame_ready = 1 the cycle after 64th accept, frame_cnt = 1; rd_addr 32 -> rd_data 16'h0100 next cycle; rd_addr 1 -> 16'h2000; rd_addr 0 -> 16'h0000.
REQ-030 Fill frame 1, then 64 more samples with no frame_done -> sample_ready = 0 after 128th accept; sample 129 offered -> overflow = 1, dropped; frame_done pulse -> frame_ready stays 1, frame_cnt = 2, sample_ready = 1 next cycle, rd_addr 1 returns frame 2 sample 32.
REQ-031 frame_done asserted in the same cycle as the 64th accept of frame 2 -> no WAIT, frame_ready never drops, frame_cnt = 2.
REQ-032 Assert rst_n low asynchronously after 20 accepts -> all outputs at REQ-026 values before next clk edge; release, 64 samples -> frame_cnt = 1 and data is from post-reset samples only.
REQ-033 sample -128 at index 0 and 127 at index 63 -> rd_addr 0 returns 16'h8000, rd_addr 63 returns 16'h7F00; frame_done pulsed while IDLE -> no state change.
